ov5640_init_sequencer: RTL
==========================

Name: ov5640_init_sequencer

Overview:
- Walks the OV5640 RAW-mode init register table entry by entry.
- Each table word is {reg_addr[15:0], data[7:0]}. The block issues one SCCB write per entry to the shared SCCB master through a req/ack/done handshake.
- Inserts the power-up delay and the post-soft-reset delay, with bounded retries per entry.
- Sits between the camera top-level and the init table ROM / SCCB master. Reports init_done or init_err to the capture pipeline.

Parameters:
- ADDR_WIDTH, 8: table address width; must match the table ROM.
- DATA_WIDTH, 24: table word width; fixed as {16-bit reg addr, 8-bit data}.
- TABLE_LEN, 86: number of valid entries, indices 0..TABLE_LEN-1. Range 1..2^ADDR_WIDTH.
- PWR_UP_DLY, 24'd480000: cycles waited after start before the first fetch (20 ms at 24 MHz).
- SOFT_RST_DLY, 24'd120000: cycles waited after a successful write of 0x3008=0x82 (5 ms at 24 MHz).
- MAX_RETRY, 3: re-attempts per entry after sccb_err before giving up.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle pulse; starts or restarts the sequence.
- rom_addr, out, ADDR_WIDTH: table ROM address.
- rom_q, in, DATA_WIDTH: table ROM data, valid 1 cycle after rom_addr (registered ROM).
- sccb_req, out, 1: write request, held until accepted.
- sccb_ack, in, 1: master accepts the request when sccb_req and sccb_ack are both high.
- sccb_reg_addr, out, 16: register address, stable while sccb_req is high.
- sccb_wdata, out, 8: register data, stable while sccb_req is high.
- sccb_done, in, 1: single-cycle pulse, write finished; at least 1 cycle after ack.
- sccb_err, in, 1: NACK flag, sampled only with sccb_done.
- busy, out, 1: high in every state except IDLE, DONE and ERROR.
- init_done, out, 1: level; all entries written.
- init_err, out, 1: level; an entry failed after MAX_RETRY retries.
- err_index, out, ADDR_WIDTH: index of the failing entry; 0 when no error.

Behaviour:
- Reset: all outputs 0; state IDLE; index, delay counter and retry counter cleared.
- Reset mid-operation:
  - sccb_req drops in the next cycle.
  - A late sccb_done from the master is ignored, because the block is in IDLE.
- States and transitions:
  - IDLE: start goes to PWR_WAIT.
  - PWR_WAIT: counts PWR_UP_DLY cycles, then goes to FETCH.
  - FETCH: drives rom_addr=index (1 cycle), then goes to LATCH.
  - LATCH: captures rom_q into sccb_reg_addr/sccb_wdata (1 cycle), then goes to ISSUE.
  - ISSUE: holds sccb_req=1. On sccb_req&sccb_ack, sccb_req goes to 0 in the next cycle and the state goes to WAIT_DONE.
  - WAIT_DONE, on sccb_done with sccb_err=0:
    - If the entry equals 24'h3008_82, go to RST_WAIT.
    - Otherwise go to NEXT.
  - WAIT_DONE, on sccb_done with sccb_err=1:
    - If retry<MAX_RETRY, increment retry and go to ISSUE with the same addr/data.
    - Otherwise latch err_index=index and go to ERROR.
  - RST_WAIT: counts SOFT_RST_DLY cycles, then goes to NEXT.
  - NEXT: clears retry.
    - If index==TABLE_LEN-1, go to DONE.
    - Otherwise increment index and go to FETCH.
  - DONE: init_done=1. start restarts the sequence.
  - ERROR: init_err=1. start restarts the sequence.
- Soft-reset detection compares the full 24-bit entry, not its index.
- Latency: with start at cycle 0, the first sccb_req rises at cycle PWR_UP_DLY+3.
- Per-entry overhead is 3 cycles plus master time; no pipelining across entries.
- Delay counters are 24 bits and load 0 on entering a wait state. A delay of 0 lasts exactly 1 cycle in the wait state.
- start outside IDLE/DONE/ERROR is ignored.
- On restart from DONE/ERROR:
  - init_done, init_err, err_index, index and retry clear in the cycle after start.
  - The sequence then proceeds as from IDLE.
- sccb_done outside WAIT_DONE is ignored. sccb_ack outside ISSUE is ignored.
- The index never exceeds TABLE_LEN-1; rom_addr never wraps.
- TABLE_LEN=1: after the single write, go straight to DONE.

Decomposition:
- Shared package ov5640_pkg holds:
  - state enum ST_IDLE, ST_PWR_WAIT, ST_FETCH, ST_LATCH, ST_ISSUE, ST_WAIT_DONE, ST_RST_WAIT, ST_NEXT, ST_DONE, ST_ERROR;
  - constant SOFT_RST_WORD=24'h3008_82;
  - field slice positions REG_ADDR_MSB=23, REG_ADDR_LSB=8.
- One sub-module: init_delay_timer (load/enable, 24-bit terminal count, expired pulse), instanced once and shared by PWR_WAIT and RST_WAIT.

Test Plan (bench params: TABLE_LEN=4, PWR_UP_DLY=10, SOFT_RST_DLY=20, MAX_RETRY=2; stub ROM {3008_82, 3103_03, 4300_03, 501f_03}):
- Nominal run: start at cycle 0, master acks immediately, done 5 cycles later. Expect:
  - first sccb_req at cycle 13 with reg_addr=16'h3008, wdata=8'h82;
  - a 20-cycle gap before entry 1;
  - 4 writes in order, then init_done=1 and busy=0.
- Retry: sccb_err=1 on the first two dones of entry 2. Expect:
  - 3 total writes of 4300_03, then entry 3 issued;
  - init_done=1, init_err=0.
- Exhausted retries: sccb_err=1 on every done of entry 1. Expect:
  - exactly 3 writes of 3103_03;
  - init_err=1, err_index=1, no request for entry 2.
- Backpressure: sccb_ack withheld 50 cycles on entry 0. Expect sccb_req high and reg_addr/wdata stable for all 50 cycles, and exactly one write.
- Reset mid-op: rst asserted during WAIT_DONE of entry 2, then a stray sccb_done. Expect:
  - all outputs 0 the next cycle;
  - stray done ignored;
  - a new start re-sends from entry 0.
- Restart and ignored start: start pulsed during RST_WAIT has no effect. start after DONE clears init_done the next cycle and repeats the 4 writes.

Source files
------------

// File: rtl/ov5640_init_sequencer_pkg.sv
// Shared types and constants for the OV5640 init sequencer.
// Pure declarations: no logic and no latency.
// Backpressure is not applicable here.
package ov5640_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_RST_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Table word that triggers the sensor soft reset (0x3008 = 0x82).
    localparam logic [23:0] SOFT_RST_WORD = 24'h3008_82;

    // Register address field inside a table word; data occupies the bits below it.
    localparam int REG_ADDR_MSB = 23;
    localparam int REG_ADDR_LSB = 8;

endpackage

// File: rtl/ov5640_init_sequencer_if.sv
// SCCB write request channel between the init sequencer and the SCCB master.
// Wires only, so there is no latency.
// The request is held until the master accepts it with ack; done/err report completion.
interface ov5640_init_sequencer_if;
    import ov5640_pkg::*;

    logic                                 sccb_req;
    logic                                 sccb_ack;
    logic [REG_ADDR_MSB-REG_ADDR_LSB:0]   sccb_reg_addr;
    logic [REG_ADDR_LSB-1:0]              sccb_wdata;
    logic                                 sccb_done;
    logic                                 sccb_err;

    modport master (
        output sccb_req, sccb_reg_addr, sccb_wdata,
        input  sccb_ack, sccb_done, sccb_err
    );

    modport slave (
        input  sccb_req, sccb_reg_addr, sccb_wdata,
        output sccb_ack, sccb_done, sccb_err
    );

endinterface

// File: rtl/ov5640_init_sequencer_timer.sv
// Shared delay counter for the power-up and soft-reset waits.
// expired_o is asserted combinationally in the last enabled cycle; a delay of 0 expires in the first one.
// No backpressure: the counter runs on every enabled cycle.
module init_delay_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [23:0] dly_i,
    output logic        expired_o
);

    logic [23:0] cnt_q;

    // Counter restarts from 0 whenever the owning wait state is not active.
    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 24'd1;
        end
    end

    assign expired_o = en_i && ((dly_i == 24'd0) || (cnt_q == dly_i - 24'd1));

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init table and issues one SCCB write per entry, with power-up/soft-reset waits and retries.
// First request PWR_UP_DLY+3 cycles after start; 3 cycles of overhead per entry plus master time.
// The request is held with stable addr/data until acked; the next entry waits for done.
module ov5640_init_sequencer
    import ov5640_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 8,
    parameter int          DATA_WIDTH   = 24,
    parameter int          TABLE_LEN    = 86,
    parameter logic [23:0] PWR_UP_DLY   = 24'd480000,
    parameter logic [23:0] SOFT_RST_DLY = 24'd120000,
    parameter int          MAX_RETRY    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]   rom_q,
    ov5640_init_sequencer_if.master sccb,
    output logic                    busy,
    output logic                    init_done,
    output logic                    init_err,
    output logic [ADDR_WIDTH-1:0]   err_index
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TABLE_LEN - 1);

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  index_q;
    logic [RETRY_W-1:0]     retry_q;
    logic [DATA_WIDTH-1:0]  entry_q;
    logic                   req_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [ADDR_WIDTH-1:0]  err_index_q;

    logic                   tmr_en;
    logic [23:0]            tmr_dly;
    logic                   tmr_expired;

    // One timer serves both waits; it is held cleared outside them so it starts at 0 on entry.
    assign tmr_en  = (state_q == ST_PWR_WAIT) || (state_q == ST_RST_WAIT);
    assign tmr_dly = (state_q == ST_PWR_WAIT) ? PWR_UP_DLY : SOFT_RST_DLY;

    init_delay_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (!tmr_en),
        .en_i      (tmr_en),
        .dly_i     (tmr_dly),
        .expired_o (tmr_expired)
    );

    // Sequencer FSM; every output is a register updated on the transition that changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            retry_q     <= '0;
            entry_q     <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q     <= ST_PWR_WAIT;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        err_index_q <= '0;
                        index_q     <= '0;
                        retry_q     <= '0;
                    end
                end
                ST_PWR_WAIT: begin
                    if (tmr_expired) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    entry_q <= rom_q;
                    req_q   <= 1'b1;
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (sccb.sccb_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (sccb.sccb_done) begin
                        if (!sccb.sccb_err) begin
                            // Match on the whole word so a reordered table still gets its reset delay.
                            state_q <= (entry_q == SOFT_RST_WORD) ? ST_RST_WAIT : ST_NEXT;
                        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            req_q   <= 1'b1;
                            state_q <= ST_ISSUE;
                        end else begin
                            err_index_q <= index_q;
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_ERROR;
                        end
                    end
                end
                ST_RST_WAIT: begin
                    if (tmr_expired) state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    retry_q <= '0;
                    if (index_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        index_q <= index_q + ADDR_WIDTH'(1);
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr           = index_q;
    assign sccb.sccb_req      = req_q;
    assign sccb.sccb_reg_addr = entry_q[REG_ADDR_MSB:REG_ADDR_LSB];
    assign sccb.sccb_wdata    = entry_q[REG_ADDR_LSB-1:0];
    assign busy               = busy_q;
    assign init_done          = done_q;
    assign init_err           = err_q;
    assign err_index          = err_index_q;

endmodule
